// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM, applies ID branch redirects
// and presents ID with {ce,pc} plus an instruction word that survives ID freezes and bubbles.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] id_inst
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_LIVE   = 2'd2;
    localparam logic [1:0] ST_HELD   = 2'd3;

    localparam logic [31:0] PC_RESET_VALUE = RESET_PC - 32'd4;

    logic        br_e;
    logic [31:0] br_addr;
    logic        if_stop;
    logic        id_stop;
    logic        ex_stop;
    logic        if_ce;

    logic [31:0] pc_q,           pc_d;
    logic        ce_q,           ce_d;
    logic        br_pend_q,      br_pend_d;
    logic [31:0] br_pend_addr_q, br_pend_addr_d;
    logic [1:0]  state_q,        state_d;
    logic [31:0] inst_hold_q,    inst_hold_d;
    logic [31:0] next_pc;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign if_stop = stall[0];
    assign id_stop = stall[1];
    assign ex_stop = stall[2];
    // A stalled IF offers ce=0 so ID never latches the same pc twice as valid.
    assign if_ce   = ce_q & ~if_stop;

    always_comb begin
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend_q) begin
            next_pc = br_pend_addr_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_d           = pc_q;
        ce_d           = ce_q;
        br_pend_d      = br_pend_q;
        br_pend_addr_d = br_pend_addr_q;
        if (!if_stop) begin
            pc_d      = next_pc;
            ce_d      = 1'b1;
            br_pend_d = 1'b0;
        end else if (br_e) begin
            br_pend_d      = 1'b1;
            br_pend_addr_d = br_addr;
        end
    end

    // Mirror of the ID pipeline register: tells whether the live SRAM word, a held copy,
    // or a nop belongs to the instruction currently sitting in ID.
    always_comb begin
        state_d     = state_q;
        inst_hold_d = inst_hold_q;
        if (id_stop && !ex_stop) begin
            state_d = ST_BUBBLE;
        end else if (!id_stop) begin
            state_d = if_ce ? ST_LIVE : ST_EMPTY;
        end else if (state_q == ST_LIVE) begin
            state_d     = ST_HELD;
            inst_hold_d = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= PC_RESET_VALUE;
            ce_q           <= 1'b0;
            br_pend_q      <= 1'b0;
            br_pend_addr_q <= 32'd0;
            state_q        <= ST_EMPTY;
            inst_hold_q    <= 32'd0;
        end else begin
            pc_q           <= pc_d;
            ce_q           <= ce_d;
            br_pend_q      <= br_pend_d;
            br_pend_addr_q <= br_pend_addr_d;
            state_q        <= state_d;
            inst_hold_q    <= inst_hold_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_LIVE: id_inst = inst_sram_rdata;
            ST_HELD: id_inst = inst_hold_q;
            default: id_inst = 32'h0000_0000;
        endcase
    end

    assign if_to_id_bus    = {if_ce, pc_q};
    assign inst_sram_en    = ce_q;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a pc-level pipeline model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares them against the DUT.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic [32:0] br_bus = 33'd0;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] id_inst;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_bus(br_bus),
        .if_to_id_bus(if_to_id_bus),
        .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2402_0005;
    endfunction

    // Synchronous SRAM; while ID is frozen the returned word is scrambled so only a held copy
    // can keep id_inst correct.
    always @(posedge clk) begin
        if (stall[1] && stall[2]) inst_sram_rdata <= $urandom;
        else                      inst_sram_rdata <= mem_word(inst_sram_addr);
    end

    typedef struct packed {
        logic [32:0] bus;
        logic [31:0] addr;
        logic        en;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference state: architectural PC, pending redirect, and which pc ID holds (if any).
    logic [31:0] m_pc, m_pend_addr, m_id_pc, m_next;
    logic        m_ce, m_pend, m_id_valid, m_if_ce;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
        exp_t e;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC - 32'd4;
            m_ce = 1'b0;
            m_pend = 1'b0;
            m_pend_addr = 32'd0;
            m_id_valid = 1'b0;
            m_id_pc = 32'd0;
        end else begin
            m_next  = br_bus[32] ? br_bus[31:0] : (m_pend ? m_pend_addr : m_pc + 32'd4);
            m_if_ce = m_ce && !stall[0];
            if (stall[1] && !stall[2]) begin
                m_id_valid = 1'b0;
            end else if (!stall[1]) begin
                m_id_valid = m_if_ce;
                m_id_pc    = m_pc;
            end
            if (!stall[0]) begin
                m_pc   = m_next;
                m_ce   = 1'b1;
                m_pend = 1'b0;
            end else if (br_bus[32]) begin
                m_pend      = 1'b1;
                m_pend_addr = br_bus[31:0];
            end
        end
        #1;
        rst = r;
        stall = s;
        br_bus = {be, ba};
        e.bus  = {m_ce && !s[0], m_pc};
        e.addr = m_pc;
        e.en   = m_ce;
        e.inst = m_id_valid ? mem_word(m_id_pc) : 32'd0;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("if_to_id_bus", if_to_id_bus, e.bus);
                chk("inst_sram_addr", {1'b0, inst_sram_addr}, {1'b0, e.addr});
                chk("inst_sram_en", {32'd0, inst_sram_en}, {32'd0, e.en});
                chk("id_inst", {1'b0, id_inst}, {1'b0, e.inst});
                chk("sram_wr", {inst_sram_wen, inst_sram_wdata[28:0]}, 33'd0);
                $display("cyc %0d addr=%h en=%b bus=%h id_inst=%h", cyc, inst_sram_addr,
                         inst_sram_en, if_to_id_bus, id_inst);
            end
        end
    end

    function automatic logic [5:0] rand_stall();
        int r;
        r = $urandom_range(0, 11);
        if (r < 7)  return 6'b000000;
        if (r < 9)  return 6'b000001;
        if (r < 10) return 6'b000011;
        return 6'b000111;
    endfunction

    initial begin : stim
        logic [31:0] ba;
        // Reset, then free-running fetch from the reset vector
        step(1'b1, 6'd0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // Branch with delay slot
        step(1'b0, 6'd0, 1'b1, 32'h8000_0100);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // Full freeze of IF/ID/EX for 4 cycles
        for (int i = 0; i < 4; i++) step(1'b0, 6'b000111, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // One-cycle ID bubble
        step(1'b0, 6'b000011, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // IF-only stall with a redirect only in its first cycle
        step(1'b0, 6'b000001, 1'b1, 32'h0000_2000);
        step(1'b0, 6'b000001, 1'b0, 32'd0);
        step(1'b0, 6'b000001, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // PC wrap at the top of the address space
        step(1'b0, 6'd0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // Reset while ID is held and a redirect is pending
        step(1'b0, 6'b000111, 1'b1, 32'h0000_4000);
        step(1'b0, 6'b000111, 1'b0, 32'd0);
        step(1'b1, 6'b000111, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 1'b0, 32'd0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ba = $urandom;
            if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFF0 | (ba & 32'hC);
            step(($urandom_range(0, 99) == 0), rand_stall(), ($urandom_range(0, 6) == 0), ba);
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
